target_slot_scheduler: RTL and testbench
========================================

// Module: target_slot_scheduler
// PURPOSE
//  Owns the 8-slot octagon target table drawn by the octagon renderers and sequences every update to it.
//  Decoded SPI words are queued in a small FIFO and committed only while vblank is high, so the table never changes mid-frame.
//  Spawns append at the tail; retires and time-based expiry pop from the head.
//  Downstream separator/octagon logic reads slots combinationally via rd_idx.
// PARAMETERS
//  SLOTS       8   target table entries (power of 2)
//  PTR_W       3   log2(SLOTS)
//  FIFO_DEPTH  4   staged-command FIFO entries (power of 2)
//  LEAD_TIME   60  ticks from spawn to target time, mod 256
// PORTS
//  pxl_clk       in   1   pixel clock; the only clock
//  reset         in   1   synchronous, active-high
//  pkt_valid     in   1   pkt_data holds a decoded SPI word
//  pkt_data      in   32  [31:30] type, [29:0] payload
//  pkt_ready     out  1   FIFO can accept a word this cycle
//  vblank        in   1   high during vertical blanking (commit window)
//  current_time  in   8   game time tick, wraps 255->0
//  rd_idx        in   PTR_W  slot index; offset from head_ptr, 0 = oldest
//  rd_word       out  32  {active[31], x[30:21], y[20:11], target_time[10:3], 3'b000}
//  slot_active   out  SLOTS  per-physical-slot active flags
//  head_ptr      out  PTR_W  physical index of the oldest slot
//  count         out  PTR_W+1  occupied slots, 0..SLOTS
//  drop_cnt      out  8   spawns dropped because the table was full; saturates at 255
//  busy          out  1   state != IDLE
// BEHAVIOUR
//  Reset (synchronous):
//  - Clears slot_active, head_ptr, count, drop_cnt, the FIFO and the table; state=IDLE.
//  - pkt_ready is 0 while reset is high and 1 on the first cycle after.
//  Intake:
//  - Accept when pkt_valid && pkt_ready; pkt_ready = !fifo_full.
//  - Push and pop in the same cycle are legal; a full FIFO with a same-cycle pop still shows pkt_ready=0.
//  - Type 2'b11 SPAWN: x=pkt[29:20], y=pkt[19:10].
//  - Type 2'b10 RETIRE: pop the head.
//  - Types 00/01 are accepted and discarded; they never enter the FIFO.
//  FSM (IDLE, EXPIRE, APPLY, DONE):
//  - IDLE -> EXPIRE on the vblank rising edge (vblank && !vblank_q).
//  - EXPIRE, one cycle per check: if count>0 and ((current_time - head.target_time) mod 256) is in 1..127, clear the head slot,
//    head_ptr+1 mod SLOTS, count-1, and stay; otherwise -> APPLY. At most SLOTS pops per frame.
//  - APPLY, one FIFO entry per cycle:
//    - SPAWN with count<SLOTS writes slot[(head_ptr+count) mod SLOTS] = {1, x, y, (current_time+LEAD_TIME) mod 256, 000}; count+1.
//    - SPAWN with count==SLOTS drops the entry; drop_cnt+1, saturating.
//    - RETIRE with count>0 clears the head; head_ptr+1, count-1.
//    - RETIRE with count==0 is a no-op.
//    - -> DONE when the FIFO is empty.
//  - vblank falling in EXPIRE or APPLY: that cycle's operation completes, then -> IDLE. Remaining entries wait for the next frame.
//  - DONE -> IDLE when vblank==0. There is one pass per vblank.
//  Latency and read port:
//  - A table write is visible on rd_word/slot_active on the next cycle.
//  - rd_word = table[(head_ptr+rd_idx) mod SLOTS], combinational. An inactive slot reads as 32'h0.
//  Widths: all pointer arithmetic wraps modulo SLOTS; time arithmetic wraps modulo 256. count never exceeds SLOTS.
//  Reset mid-APPLY/EXPIRE: in-flight commands are lost and the table is cleared.
// TESTING
//  1. Reset, then SPAWN x=200,y=300 at current_time=10 with vblank low -> table unchanged. Then pulse vblank -> count=1, rd_word(0)={1,200,300,70,000}.
//  2. 9 SPAWNs over two frames -> count=8, drop_cnt=1, and the 9th never appears in the table.
//  3. Fill to 8 entries at time 250 (target 54 after wrap); vblank at time 55 -> all 8 expire in 8 EXPIRE cycles; count=0, head_ptr unchanged mod 8.
//  4. RETIRE with count=0 -> no change. Then SPAWN, SPAWN, RETIRE in one window -> count=1, and head holds the 2nd spawn.
//  5. Hold pkt_valid with 5 SPAWNs while vblank is low -> pkt_ready drops after 4. A type-01 word is still discarded without entering the FIFO.
//  6. Deassert vblank after the 2nd APPLY cycle -> 2 entries are committed and the rest commit on the next vblank. Assert reset mid-APPLY -> all outputs return to reset values.

Source files
------------

// File: rtl/target_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : target_slot_scheduler
// Description : 8-slot octagon target table with a staged SPI command FIFO;
//               updates are committed only inside the vblank window.
// Revision    : 1.0 - initial release
// ============================================================================
module target_slot_scheduler #(
    parameter int SLOTS      = 8,
    parameter int PTR_W      = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int LEAD_TIME  = 60
) (
    input  logic             pxl_clk,
    input  logic             reset,
    input  logic             pkt_valid,
    input  logic [31:0]      pkt_data,
    output logic             pkt_ready,
    input  logic             vblank,
    input  logic [7:0]       current_time,
    input  logic [PTR_W-1:0] rd_idx,
    output logic [31:0]      rd_word,
    output logic [SLOTS-1:0] slot_active,
    output logic [PTR_W-1:0] head_ptr,
    output logic [PTR_W:0]   count,
    output logic [7:0]       drop_cnt,
    output logic             busy
);

    localparam int                 c_FIFO_AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]     c_SLOTS_CNT = (PTR_W + 1)'(SLOTS);
    localparam logic [c_FIFO_AW:0] c_FIFO_FULL = (c_FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]         c_LEAD      = 8'(LEAD_TIME);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPIRE = 2'd1,
        S_APPLY  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_vblank_q;

    // Staged command entry: {is_spawn, x[9:0], y[9:0]}
    logic [20:0]          r_fifo [FIFO_DEPTH];
    logic [c_FIFO_AW-1:0] r_fifo_wr;
    logic [c_FIFO_AW-1:0] r_fifo_rd;
    logic [c_FIFO_AW:0]   r_fifo_cnt;

    logic [SLOTS-1:0] r_active;
    logic [9:0]       r_x  [SLOTS];
    logic [9:0]       r_y  [SLOTS];
    logic [7:0]       r_tt [SLOTS];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W:0]   r_count;
    logic [7:0]       r_drop;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_fifo_push;
    logic             w_fifo_pop;
    logic [20:0]      w_fifo_head;
    logic [7:0]       w_age;
    logic             w_expire_hit;
    logic             w_pop_head;
    logic             w_spawn_wr;
    logic             w_drop;
    logic [PTR_W-1:0] w_tail;
    logic [PTR_W-1:0] w_rd_phys;
    logic             w_unused;

    assign w_fifo_full  = (r_fifo_cnt == c_FIFO_FULL);
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign pkt_ready    = !reset && !w_fifo_full;
    // Types 00/01 complete the handshake but are never staged
    assign w_fifo_push  = pkt_valid && pkt_ready && pkt_data[31];
    assign w_fifo_head  = r_fifo[r_fifo_rd];
    assign w_unused     = &{1'b0, pkt_data[9:0]};

    // Head is overdue when it lies 1..127 ticks in the past (modulo 256)
    assign w_age        = current_time - r_tt[r_head];
    assign w_expire_hit = (r_count != '0) && (w_age != 8'd0) && !w_age[7];
    assign w_tail       = r_head + r_count[PTR_W-1:0];

    always_comb begin
        w_state_next = r_state;
        w_pop_head   = 1'b0;
        w_spawn_wr   = 1'b0;
        w_drop       = 1'b0;
        w_fifo_pop   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (vblank && !r_vblank_q) begin
                    w_state_next = S_EXPIRE;
                end
            end
            S_EXPIRE: begin
                if (w_expire_hit) begin
                    w_pop_head = 1'b1;
                end else begin
                    w_state_next = S_APPLY;
                end
                if (!vblank) begin
                    w_state_next = S_IDLE;
                end
            end
            S_APPLY: begin
                if (w_fifo_empty) begin
                    w_state_next = S_DONE;
                end else begin
                    w_fifo_pop = 1'b1;
                    if (w_fifo_head[20]) begin
                        if (r_count < c_SLOTS_CNT) begin
                            w_spawn_wr = 1'b1;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end else if (r_count != '0) begin
                        w_pop_head = 1'b1;
                    end
                end
                if (!vblank) begin
                    w_state_next = S_IDLE;
                end
            end
            S_DONE: begin
                if (!vblank) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pxl_clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_vblank_q <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_vblank_q <= vblank;
        end
    end

    always_ff @(posedge pxl_clk) begin
        if (reset) begin
            r_fifo_wr  <= '0;
            r_fifo_rd  <= '0;
            r_fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_fifo_push) begin
                r_fifo[r_fifo_wr] <= {pkt_data[30], pkt_data[29:10]};
                r_fifo_wr         <= r_fifo_wr + 1'b1;
            end
            if (w_fifo_pop) begin
                r_fifo_rd <= r_fifo_rd + 1'b1;
            end
            case ({w_fifo_push, w_fifo_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Head pop and tail write are mutually exclusive within a cycle
    always_ff @(posedge pxl_clk) begin
        if (reset) begin
            r_active <= '0;
            r_head   <= '0;
            r_count  <= '0;
            r_drop   <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_x[i]  <= '0;
                r_y[i]  <= '0;
                r_tt[i] <= '0;
            end
        end else begin
            if (w_pop_head) begin
                r_active[r_head] <= 1'b0;
                r_head           <= r_head + 1'b1;
                r_count          <= r_count - 1'b1;
            end else if (w_spawn_wr) begin
                r_active[w_tail] <= 1'b1;
                r_x[w_tail]      <= w_fifo_head[19:10];
                r_y[w_tail]      <= w_fifo_head[9:0];
                r_tt[w_tail]     <= current_time + c_LEAD;
                r_count          <= r_count + 1'b1;
            end
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign w_rd_phys   = r_head + rd_idx;
    assign rd_word     = r_active[w_rd_phys] ?
                         {1'b1, r_x[w_rd_phys], r_y[w_rd_phys], r_tt[w_rd_phys], 3'b000} :
                         32'h0;
    assign slot_active = r_active;
    assign head_ptr    = r_head;
    assign count       = r_count;
    assign drop_cnt    = r_drop;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_target_slot_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_target_slot_scheduler
// Description : Scoreboard bench; a queue-based table model predicts the
//               table after every vblank pass, a monitor checks it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_target_slot_scheduler;

    localparam int c_LEAD = 60;

    logic        pxl_clk      = 1'b0;
    logic        reset        = 1'b1;
    logic        pkt_valid    = 1'b0;
    logic [31:0] pkt_data     = 32'h0;
    logic        vblank       = 1'b0;
    logic [7:0]  current_time = 8'h0;
    logic [2:0]  rd_idx       = 3'h0;
    logic        pkt_ready;
    logic [31:0] rd_word;
    logic [7:0]  slot_active;
    logic [2:0]  head_ptr;
    logic [3:0]  count;
    logic [7:0]  drop_cnt;
    logic        busy;

    target_slot_scheduler dut (
        .pxl_clk      (pxl_clk),
        .reset        (reset),
        .pkt_valid    (pkt_valid),
        .pkt_data     (pkt_data),
        .pkt_ready    (pkt_ready),
        .vblank       (vblank),
        .current_time (current_time),
        .rd_idx       (rd_idx),
        .rd_word      (rd_word),
        .slot_active  (slot_active),
        .head_ptr     (head_ptr),
        .count        (count),
        .drop_cnt     (drop_cnt),
        .busy         (busy)
    );

    always #5 pxl_clk = ~pxl_clk;

    typedef struct packed {
        logic [3:0]       cnt;
        logic [2:0]       head;
        logic [7:0]       drop;
        logic [7:0]       act;
        logic [7:0][31:0] w;
    } snap_t;

    // Reference model: logical table (oldest first), staged commands, counters
    logic [31:0] mq[$];
    logic [20:0] mfifo[$];
    int          mhead;
    int          mdrop;
    snap_t       expq[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_spawn(input int x, input int y);
        logic [9:0] xv;
        logic [9:0] yv;
        xv = 10'(x);
        yv = 10'(y);
        return {2'b11, xv, yv, 10'h0};
    endfunction

    task automatic model_reset();
        mq.delete();
        mfifo.delete();
        mhead = 0;
        mdrop = 0;
    endtask

    // One vblank pass: expire overdue heads, then apply up to 'limit' commands
    task automatic model_frame(input int t, input int limit);
        int          n;
        int          d;
        logic [20:0] e;
        while (mq.size() > 0) begin
            d = (t - int'(mq[0][10:3])) & 255;
            if (d >= 1 && d <= 127) begin
                void'(mq.pop_front());
                mhead = (mhead + 1) % 8;
            end else begin
                break;
            end
        end
        n = 0;
        while (mfifo.size() > 0 && n < limit) begin
            e = mfifo.pop_front();
            n++;
            if (e[20]) begin
                if (mq.size() < 8) mq.push_back({1'b1, e[19:10], e[9:0], 8'(t + c_LEAD), 3'b000});
                else if (mdrop < 255) mdrop++;
            end else if (mq.size() > 0) begin
                void'(mq.pop_front());
                mhead = (mhead + 1) % 8;
            end
        end
    endtask

    function automatic snap_t make_snap();
        snap_t s;
        s      = '0;
        s.cnt  = 4'(mq.size());
        s.head = 3'(mhead);
        s.drop = 8'(mdrop);
        for (int i = 0; i < mq.size(); i++) begin
            s.act[(mhead + i) % 8] = 1'b1;
            s.w[i] = mq[i];
        end
        return s;
    endfunction

    // Called at a negedge; the word is offered for one clock
    task automatic send(input logic [31:0] w);
        logic exp_rdy;
        pkt_valid = 1'b1;
        pkt_data  = w;
        exp_rdy   = (mfifo.size() < 4);
        #1;
        chk("pkt_ready", 32'(pkt_ready), 32'(exp_rdy));
        if (exp_rdy && w[31]) mfifo.push_back({w[30], w[29:20], w[19:10]});
        @(negedge pxl_clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pkt_valid = 1'b0;
        vblank    = 1'b0;
        @(negedge pxl_clk);
        chk("rst_ready_low", 32'(pkt_ready), 32'd0);
        repeat (2) @(negedge pxl_clk);
        reset = 1'b0;
        model_reset();
        @(negedge pxl_clk);
        chk("rst_ready_high", 32'(pkt_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_head", 32'(head_ptr), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_active", 32'(slot_active), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_frame(input int t);
        current_time = 8'(t);
        model_frame(t, 1000);
        expq.push_back(make_snap());
        vblank = 1'b1;
        repeat (24) @(negedge pxl_clk);
        vblank = 1'b0;
        repeat (4) @(negedge pxl_clk);
    endtask

    // Window closes after the second APPLY cycle (table must be empty so EXPIRE lasts one cycle)
    task automatic partial_frame(input int t, input int n);
        current_time = 8'(t);
        model_frame(t, n);
        expq.push_back(make_snap());
        vblank = 1'b1;
        repeat (3) @(posedge pxl_clk);
        @(negedge pxl_clk);
        vblank = 1'b0;
        repeat (4) @(negedge pxl_clk);
    endtask

    // Monitor: compare the full table whenever a pass finishes (busy falls)
    initial begin
        logic  bq;
        logic  cur;
        snap_t e;
        bq = 1'b0;
        forever begin
            @(negedge pxl_clk);
            cur = busy;
            if (bq && !cur) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pass actual=pass_end required=no_pass");
                end else begin
                    e = expq.pop_front();
                    chk("mon_count", 32'(count), 32'(e.cnt));
                    chk("mon_head", 32'(head_ptr), 32'(e.head));
                    chk("mon_drop", 32'(drop_cnt), 32'(e.drop));
                    chk("mon_active", 32'(slot_active), 32'(e.act));
                    for (int i = 0; i < 8; i++) begin
                        rd_idx = 3'(i);
                        #1;
                        chk("mon_rd_word", rd_word, e.w[i]);
                    end
                    rd_idx = 3'h0;
                end
            end
            bq = cur;
        end
    end

    initial begin
        int t;
        model_reset();
        do_reset();

        // 1: staged spawn is invisible until vblank
        send(mk_spawn(200, 300));
        pkt_valid = 1'b0;
        current_time = 8'd10;
        repeat (3) @(negedge pxl_clk);
        chk("hold_count", 32'(count), 32'(mq.size()));
        chk("hold_active", 32'(slot_active), 32'd0);
        run_frame(10);
        chk("t1_word0", rd_word, {1'b1, 10'd200, 10'd300, 8'd70, 3'b000});

        // 2: nine spawns, the last one dropped
        do_reset();
        for (int k = 0; k < 4; k++) send(mk_spawn(k, k + 1));
        pkt_valid = 1'b0;
        run_frame(10);
        for (int k = 4; k < 8; k++) send(mk_spawn(k, k + 1));
        pkt_valid = 1'b0;
        run_frame(10);
        send(mk_spawn(999, 999));
        pkt_valid = 1'b0;
        run_frame(10);

        // 3: full table at t=250 (target 54) expires entirely at t=55
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 4; k++) send(mk_spawn(f * 4 + k, 7));
            pkt_valid = 1'b0;
            run_frame(250);
        end
        run_frame(55);

        // 4: retire on empty, then spawn/spawn/retire
        do_reset();
        send(32'h8000_0000);
        pkt_valid = 1'b0;
        run_frame(100);
        send(mk_spawn(11, 12));
        send(mk_spawn(21, 22));
        send(32'h8000_0000);
        pkt_valid = 1'b0;
        run_frame(100);

        // 5: back-pressure after four staged words; type-01 never occupies the FIFO
        do_reset();
        for (int k = 0; k < 5; k++) send(mk_spawn(100 + k, 5));
        send(32'h4000_1234);
        pkt_valid = 1'b0;
        run_frame(30);
        for (int k = 0; k < 3; k++) send(mk_spawn(200 + k, 6));
        send(32'h4ABC_DEF0);
        send(mk_spawn(300, 9));
        pkt_valid = 1'b0;
        run_frame(30);

        // 6: early vblank fall, then reset in the middle of APPLY
        do_reset();
        for (int k = 0; k < 4; k++) send(mk_spawn(400 + k, 10 + k));
        pkt_valid = 1'b0;
        partial_frame(20, 2);
        run_frame(20);
        for (int k = 0; k < 4; k++) send(mk_spawn(500 + k, 3));
        pkt_valid = 1'b0;
        vblank = 1'b1;
        repeat (3) @(posedge pxl_clk);
        @(negedge pxl_clk);
        model_reset();
        expq.push_back(make_snap());
        reset  = 1'b1;
        vblank = 1'b0;
        @(negedge pxl_clk);
        chk("midrst_ready_low", 32'(pkt_ready), 32'd0);
        repeat (2) @(negedge pxl_clk);
        reset = 1'b0;
        @(negedge pxl_clk);
        chk("midrst_ready_high", 32'(pkt_ready), 32'd1);

        // Randomized frames
        do_reset();
        t = 0;
        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) begin
                logic [31:0] w;
                w = $urandom;
                if ($urandom_range(0, 2) != 0) w[31:30] = 2'b11;
                if ($urandom_range(0, 3) == 0) begin
                    pkt_valid = 1'b0;
                    @(negedge pxl_clk);
                end
                send(w);
            end
            pkt_valid = 1'b0;
            t = (t + $urandom_range(0, 90)) % 256;
            run_frame(t);
        end

        repeat (10) @(negedge pxl_clk);
        chk("expect_queue_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
